// File: rtl/jtag_dtm_pkg.sv
// Shared types for the RISC-V JTAG DTM: TAP states, IR codes, DMI op/resp codes, DTMCS layout.
package jtag_dtm_pkg;

  typedef enum logic [3:0] {
    TAP_EX2_DR   = 4'h0, TAP_EX1_DR   = 4'h1, TAP_SH_DR  = 4'h2, TAP_PAUSE_DR = 4'h3,
    TAP_SEL_IR   = 4'h4, TAP_UPD_DR   = 4'h5, TAP_CAP_DR = 4'h6, TAP_SEL_DR   = 4'h7,
    TAP_EX2_IR   = 4'h8, TAP_EX1_IR   = 4'h9, TAP_SH_IR  = 4'hA, TAP_PAUSE_IR = 4'hB,
    TAP_RTI      = 4'hC, TAP_UPD_IR   = 4'hD, TAP_CAP_IR = 4'hE, TAP_TLR      = 4'hF
  } tap_state_e;

  localparam logic [4:0] IR_IDCODE  = 5'h01;
  localparam logic [4:0] IR_DTMCS   = 5'h10;
  localparam logic [4:0] IR_DMI     = 5'h11;
  localparam logic [4:0] IR_BYPASS  = 5'h1F;
  localparam logic [4:0] IR_CAPTURE = 5'b00001;

  localparam logic [1:0] DMI_OP_NOP   = 2'd0;
  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;

  localparam logic [1:0] DMI_RESP_OK     = 2'd0;
  localparam logic [1:0] DMI_RESP_FAILED = 2'd2;
  localparam logic [1:0] DMI_RESP_BUSY   = 2'd3;

  localparam int DTMCS_VERSION_LSB = 0;
  localparam int DTMCS_ABITS_LSB   = 4;
  localparam int DTMCS_DMISTAT_LSB = 10;
  localparam int DTMCS_IDLE_LSB    = 12;
  localparam int DTMCS_DMIRESET    = 16;
  localparam int DTMCS_HARDRESET   = 17;

  typedef struct packed {
    logic [13:0] zero_hi;
    logic        dmihardreset;
    logic        dmireset;
    logic        zero_lo;
    logic [2:0]  idle;
    logic [1:0]  dmistat;
    logic [5:0]  abits;
    logic [3:0]  version;
  } dtmcs_t;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    case (s)
      TAP_TLR:      return tms ? TAP_TLR    : TAP_RTI;
      TAP_RTI:      return tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR:   return tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR:   return tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:    return tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR:   return tms ? TAP_UPD_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR: return tms ? TAP_EX2_DR : TAP_PAUSE_DR;
      TAP_EX2_DR:   return tms ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR:   return tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR:   return tms ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR:   return tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:    return tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR:   return tms ? TAP_UPD_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR: return tms ? TAP_EX2_IR : TAP_PAUSE_IR;
      TAP_EX2_IR:   return tms ? TAP_UPD_IR : TAP_SH_IR;
      TAP_UPD_IR:   return tms ? TAP_SEL_DR : TAP_RTI;
      default:      return TAP_TLR;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller; strobes are registered alongside the state so they
// are high exactly while the TAP sits in the matching state.
module jtag_tap_fsm
  import jtag_dtm_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_e state,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr
);

  tap_state_e nxt;
  assign nxt = tap_next(state, tms);

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      state      <= TAP_TLR;
      capture_ir <= 1'b0;
      shift_ir   <= 1'b0;
      update_ir  <= 1'b0;
      capture_dr <= 1'b0;
      shift_dr   <= 1'b0;
      update_dr  <= 1'b0;
    end else begin
      state      <= nxt;
      capture_ir <= (nxt == TAP_CAP_IR);
      shift_ir   <= (nxt == TAP_SH_IR);
      update_ir  <= (nxt == TAP_UPD_IR);
      capture_dr <= (nxt == TAP_CAP_DR);
      shift_dr   <= (nxt == TAP_SH_DR);
      update_dr  <= (nxt == TAP_UPD_DR);
    end
  end

endmodule

// File: rtl/jtag_riscv_dtm.sv
// RISC-V JTAG DTM: IR, IDCODE/DTMCS/DMI/BYPASS data registers and the DMI handshake.
// Define TDO_NEGEDGE_EN to re-time TDO on the falling edge of TCK.
module jtag_riscv_dtm
  import jtag_dtm_pkg::*;
#(
  parameter int          ABITS    = 7,
  parameter logic [31:0] IDCODE   = 32'h1000_0CFD,
  parameter int          IR_WIDTH = 5
) (
  input  logic             TCK,
  input  logic             TRST,
  input  logic             TMS,
  input  logic             TDI,
  output logic             TDO,
  output logic             DMI_REQ_VALID,
  input  logic             DMI_REQ_READY,
  output logic [ABITS-1:0] DMI_REQ_ADDR,
  output logic [31:0]      DMI_REQ_DATA,
  output logic [1:0]       DMI_REQ_OP,
  input  logic             DMI_RESP_VALID,
  input  logic [31:0]      DMI_RESP_DATA,
  input  logic [1:0]       DMI_RESP_RESP
);

  localparam int DMI_W = ABITS + 34;

  typedef enum logic [1:0] {DR_BYPASS, DR_IDCODE, DR_DTMCS, DR_DMI} dr_sel_e;

  tap_state_e tap_state;
  logic capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr;

  jtag_tap_fsm u_tap (
    .tck       (TCK),
    .trst      (TRST),
    .tms       (TMS),
    .state     (tap_state),
    .capture_ir(capture_ir),
    .shift_ir  (shift_ir),
    .update_ir (update_ir),
    .capture_dr(capture_dr),
    .shift_dr  (shift_dr),
    .update_dr (update_dr)
  );

  logic [IR_WIDTH-1:0] ir, ir_sr;
  logic [DMI_W-1:0]    dr_sr, dr_cap, dr_shift;
  logic [1:0]          dmistat;
  logic                outstanding;
  logic [ABITS-1:0]    last_addr;
  logic [31:0]         last_data;
  dr_sel_e             dr_sel;
  dtmcs_t              dtmcs_rd;
  logic                tdo_comb;

  logic [ABITS-1:0] upd_addr;
  logic [31:0]      upd_data;
  logic [1:0]       upd_op;
  assign upd_addr = dr_sr[DMI_W-1 -: ABITS];
  assign upd_data = dr_sr[33:2];
  assign upd_op   = dr_sr[1:0];

  always_comb begin
    dr_sel = DR_BYPASS;
    case (ir)
      IR_WIDTH'(IR_IDCODE): dr_sel = DR_IDCODE;
      IR_WIDTH'(IR_DTMCS):  dr_sel = DR_DTMCS;
      IR_WIDTH'(IR_DMI):    dr_sel = DR_DMI;
      IR_WIDTH'(IR_BYPASS): dr_sel = DR_BYPASS;
      default:              dr_sel = DR_BYPASS;
    endcase
  end

  always_comb begin
    dtmcs_rd         = '0;
    dtmcs_rd.idle    = 3'd1;
    dtmcs_rd.dmistat = dmistat;
    dtmcs_rd.abits   = 6'(ABITS);
    dtmcs_rd.version = 4'd1;
  end

  // Every DR shares one shift register; TDI enters at the MSB of the selected width.
  always_comb begin
    dr_cap   = '0;
    dr_shift = DMI_W'(TDI);
    case (dr_sel)
      DR_IDCODE: begin
        dr_cap   = DMI_W'(IDCODE);
        dr_shift = DMI_W'({TDI, dr_sr[31:1]});
      end
      DR_DTMCS: begin
        dr_cap   = DMI_W'(dtmcs_rd);
        dr_shift = DMI_W'({TDI, dr_sr[31:1]});
      end
      DR_DMI: begin
        dr_cap   = {last_addr, last_data, outstanding ? DMI_RESP_BUSY : dmistat};
        dr_shift = {TDI, dr_sr[DMI_W-1:1]};
      end
      default: begin
        dr_cap   = '0;
        dr_shift = DMI_W'(TDI);
      end
    endcase
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      ir            <= IR_WIDTH'(IR_IDCODE);
      ir_sr         <= '0;
      dr_sr         <= '0;
      dmistat       <= DMI_RESP_OK;
      outstanding   <= 1'b0;
      last_addr     <= '0;
      last_data     <= '0;
      DMI_REQ_VALID <= 1'b0;
      DMI_REQ_ADDR  <= '0;
      DMI_REQ_DATA  <= '0;
      DMI_REQ_OP    <= DMI_OP_NOP;
    end else begin
      if (tap_state == TAP_TLR) ir <= IR_WIDTH'(IR_IDCODE);
      else if (update_ir)       ir <= ir_sr;

      if (capture_ir)    ir_sr <= IR_WIDTH'(IR_CAPTURE);
      else if (shift_ir) ir_sr <= {TDI, ir_sr[IR_WIDTH-1:1]};

      if (capture_dr)    dr_sr <= dr_cap;
      else if (shift_dr) dr_sr <= dr_shift;

      if (DMI_REQ_VALID && DMI_REQ_READY) DMI_REQ_VALID <= 1'b0;

      if (DMI_RESP_VALID && outstanding) begin
        last_data   <= DMI_RESP_DATA;
        outstanding <= 1'b0;
        if (DMI_RESP_RESP != DMI_RESP_OK) dmistat <= DMI_RESP_RESP;
      end

      // A scan that observes a busy DMI is sticky-flagged until dmireset.
      if (capture_dr && dr_sel == DR_DMI && outstanding) dmistat <= DMI_RESP_BUSY;

      if (update_dr) begin
        case (dr_sel)
          DR_DTMCS: begin
            if (dr_sr[DTMCS_DMIRESET] || dr_sr[DTMCS_HARDRESET]) dmistat <= DMI_RESP_OK;
            if (dr_sr[DTMCS_HARDRESET]) begin
              DMI_REQ_VALID <= 1'b0;
              outstanding   <= 1'b0;
            end
          end
          DR_DMI: begin
            if (outstanding) begin
              dmistat <= DMI_RESP_BUSY;
            end else if ((upd_op == DMI_OP_READ || upd_op == DMI_OP_WRITE) &&
                         dmistat == DMI_RESP_OK) begin
              DMI_REQ_VALID <= 1'b1;
              DMI_REQ_ADDR  <= upd_addr;
              DMI_REQ_DATA  <= upd_data;
              DMI_REQ_OP    <= upd_op;
              last_addr     <= upd_addr;
              outstanding   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign tdo_comb = shift_ir ? ir_sr[0] : (shift_dr ? dr_sr[0] : 1'b0);

`ifdef TDO_NEGEDGE_EN
  logic tdo_q;
  always_ff @(negedge TCK or posedge TRST) begin
    if (TRST) tdo_q <= 1'b0;
    else      tdo_q <= tdo_comb;
  end
  assign TDO = tdo_q;
`else
  assign TDO = tdo_comb;
`endif

endmodule

// File: tb/tb_jtag_riscv_dtm.sv
// Bench for jtag_riscv_dtm: vector table, directed corner sequences, and random scans
// checked against a transaction-level DTM model.
module tb_jtag_riscv_dtm;
  localparam int          ABITS = 7;
  localparam logic [31:0] IDC   = 32'h1000_0CFD;

  logic        TCK, TRST, TMS, TDI, TDO;
  logic        DMI_REQ_VALID, DMI_REQ_READY;
  logic [6:0]  DMI_REQ_ADDR;
  logic [31:0] DMI_REQ_DATA;
  logic [1:0]  DMI_REQ_OP;
  logic        DMI_RESP_VALID;
  logic [31:0] DMI_RESP_DATA;
  logic [1:0]  DMI_RESP_RESP;

  jtag_riscv_dtm #(.ABITS(ABITS), .IDCODE(IDC), .IR_WIDTH(5)) dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO),
    .DMI_REQ_VALID(DMI_REQ_VALID), .DMI_REQ_READY(DMI_REQ_READY),
    .DMI_REQ_ADDR(DMI_REQ_ADDR), .DMI_REQ_DATA(DMI_REQ_DATA), .DMI_REQ_OP(DMI_REQ_OP),
    .DMI_RESP_VALID(DMI_RESP_VALID), .DMI_RESP_DATA(DMI_RESP_DATA), .DMI_RESP_RESP(DMI_RESP_RESP)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  int n_checks, n_fail;

  // Transaction-level model of the DTM's programmer-visible state.
  logic [4:0]  m_ir;
  logic [1:0]  m_stat;
  bit          m_busy;
  logic [6:0]  m_addr;
  logic [31:0] m_data;
  bit          e_valid;
  logic [6:0]  e_addr;
  logic [31:0] e_wdata;
  logic [1:0]  e_op;

  typedef struct {
    logic [4:0]  ir;
    int          w;
    logic [63:0] din;
    logic [63:0] exp;
    string       nm;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    m_ir = 5'h01; m_stat = 2'd0; m_busy = 0; m_addr = '0; m_data = '0;
    e_valid = 0; e_addr = '0; e_wdata = '0; e_op = '0;
  endtask

  function automatic int m_width(input logic [4:0] ir);
    if (ir == 5'h01 || ir == 5'h10) return 32;
    if (ir == 5'h11) return ABITS + 34;
    return 1;
  endfunction

  task automatic m_capture(output logic [63:0] v);
    v = '0;
    if (m_ir == 5'h01) v = 64'(IDC);
    else if (m_ir == 5'h10)
      v = 64'(32'h0000_1000 + (32'(m_stat) << 10) + (32'(ABITS) << 4) + 32'd1);
    else if (m_ir == 5'h11) begin
      if (m_busy) m_stat = 2'd3;
      v = {23'd0, m_addr, m_data, m_busy ? 2'd3 : m_stat};
    end
  endtask

  task automatic m_update(input logic [63:0] v);
    if (m_ir == 5'h10) begin
      if (v[16] || v[17]) m_stat = 2'd0;
      if (v[17]) begin m_busy = 0; e_valid = 0; end
    end else if (m_ir == 5'h11) begin
      if (m_busy) m_stat = 2'd3;
      else if ((v[1:0] == 2'd1 || v[1:0] == 2'd2) && m_stat == 2'd0) begin
        m_busy = 1; e_valid = 1;
        e_addr = v[40:34]; e_wdata = v[33:2]; e_op = v[1:0];
        m_addr = v[40:34];
      end
    end
  endtask

  task automatic clk1(input logic tms, input logic tdi, output logic tdo);
    @(negedge TCK);
    TMS = tms; TDI = tdi;
    #1 tdo = TDO;
    @(posedge TCK);
    #1;
  endtask

  task automatic idle();
    logic d;
    clk1(1'b0, 1'b0, d);
    if (DMI_REQ_READY) e_valid = 0;
    chk("req_valid_idle", 64'(DMI_REQ_VALID), 64'(e_valid));
  endtask

  task automatic scan_ir(input logic [4:0] v, output logic [4:0] o);
    logic t;
    clk1(1, 0, t); clk1(1, 0, t); clk1(0, 0, t); clk1(0, 0, t);
    for (int i = 0; i < 5; i++) begin clk1(i == 4, v[i], t); o[i] = t; end
    clk1(1, 0, t); clk1(0, 0, t);
  endtask

  task automatic scan_dr(input int w, input logic [63:0] v, output logic [63:0] o);
    logic t;
    o = '0;
    clk1(1, 0, t); clk1(0, 0, t); clk1(0, 0, t);
    for (int i = 0; i < w; i++) begin clk1(i == w - 1, v[i], t); o[i] = t; end
    clk1(1, 0, t); clk1(0, 0, t);
  endtask

  task automatic do_ir(input logic [4:0] v);
    logic [4:0] o;
    scan_ir(v, o);
    chk("ir_capture", 64'(o), 64'h1);
    m_ir = v;
  endtask

  task automatic do_dr(input logic [63:0] v);
    logic [63:0] o, exp;
    int w;
    w = m_width(m_ir);
    m_capture(exp);
    scan_dr(w, v, o);
    chk("dr_capture", o, exp);
    m_update(v);
    chk("req_valid", 64'(DMI_REQ_VALID), 64'(e_valid));
    chk("req_addr", 64'(DMI_REQ_ADDR), 64'(e_addr));
    chk("req_data", 64'(DMI_REQ_DATA), 64'(e_wdata));
    chk("req_op", 64'(DMI_REQ_OP), 64'(e_op));
  endtask

  task automatic do_resp(input logic [1:0] r, input logic [31:0] d);
    @(negedge TCK);
    TMS = 0; DMI_RESP_VALID = 1; DMI_RESP_DATA = d; DMI_RESP_RESP = r;
    @(posedge TCK);
    #1 DMI_RESP_VALID = 0;
    if (e_valid && DMI_REQ_READY) e_valid = 0;
    if (m_busy) begin
      m_data = d;
      if (r != 2'd0) m_stat = r;
      m_busy = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end

  initial begin
    logic d;
    logic [63:0] o, din;
    int a;
    n_checks = 0; n_fail = 0;
    TRST = 1; TMS = 1; TDI = 0;
    DMI_REQ_READY = 1; DMI_RESP_VALID = 0; DMI_RESP_DATA = '0; DMI_RESP_RESP = '0;
    m_reset();

    tbl[0] = '{5'h01, 32, 64'h0, 64'h1000_0CFD, "idcode"};
    tbl[1] = '{5'h10, 32, 64'h0, 64'h0000_1071, "dtmcs"};
    tbl[2] = '{5'h1F, 1, 64'h1, 64'h0, "bypass_1bit"};
    tbl[3] = '{5'h1F, 5, 64'h0D, 64'h1A, "bypass_pattern"};
    tbl[4] = '{5'h05, 1, 64'h0, 64'h0, "unknown_ir_bypass"};
    tbl[5] = '{5'h11, 41, 64'h0, 64'h0, "dmi_idle"};

    repeat (3) @(posedge TCK);
    #1;
    chk("reset_tdo", 64'(TDO), 64'h0);
    chk("reset_valid", 64'(DMI_REQ_VALID), 64'h0);
    chk("reset_addr", 64'(DMI_REQ_ADDR), 64'h0);
    chk("reset_data", 64'(DMI_REQ_DATA), 64'h0);
    chk("reset_op", 64'(DMI_REQ_OP), 64'h0);
    #1 TRST = 0;

    // IDCODE is selected straight out of Test-Logic-Reset.
    repeat (5) clk1(1, 0, d);
    clk1(0, 0, d);
    do_dr(64'h0);

    foreach (tbl[i]) begin
      do_ir(tbl[i].ir);
      scan_dr(tbl[i].w, tbl[i].din, o);
      chk(tbl[i].nm, o, tbl[i].exp);
      m_update(tbl[i].din);
    end

    // Write issued and accepted, then an OK response.
    do_ir(5'h11);
    do_dr({23'd0, 7'h10, 32'h1, 2'd2});
    idle();
    do_resp(2'd0, 32'h1234_5678);
    do_dr(64'h0);

    // Stalled DM: busy capture, dmireset, then dmihardreset drops the request.
    DMI_REQ_READY = 0;
    do_dr({23'd0, 7'h22, 32'hCAFE_F00D, 2'd2});
    idle();
    do_dr({23'd0, 7'h33, 32'h0, 2'd1});
    do_ir(5'h10);
    do_dr(64'h1 << 16);
    do_dr(64'h1 << 17);
    DMI_REQ_READY = 1;
    idle();
    do_resp(2'd2, 32'hBAD0_BAD0);
    do_ir(5'h11);
    do_dr(64'h0);

    // Failed read leaves dmistat set and blocks scans until dmireset.
    do_dr({23'd0, 7'h05, 32'h0, 2'd1});
    idle();
    do_resp(2'd2, 32'hDEAD_BEEF);
    do_dr({23'd0, 7'h06, 32'h1, 2'd2});
    idle();
    do_dr({23'd0, 7'h07, 32'h2, 2'd1});
    do_ir(5'h10);
    do_dr(64'h1 << 16);
    do_ir(5'h11);
    do_dr({23'd0, 7'h08, 32'h3, 2'd1});
    idle();
    do_resp(2'd0, 32'h0BAD_F00D);

    for (int k = 0; k < 80; k++) begin
      a = $urandom_range(0, 9);
      if (a < 2) begin
        case ($urandom_range(0, 6))
          0: do_ir(5'h01);
          1: do_ir(5'h10);
          2, 3, 4: do_ir(5'h11);
          5: do_ir(5'h1F);
          default: do_ir(5'($urandom));
        endcase
      end else if (a < 7) begin
        din = {$urandom, $urandom};
        if (m_ir == 5'h10) begin
          din[17] = ($urandom_range(0, 4) == 0);
          din[16] = ($urandom_range(0, 2) == 0);
        end
        din = din & ((64'h1 << m_width(m_ir)) - 64'h1);
        do_dr(din);
        idle();
      end else begin
        case ($urandom_range(0, 3))
          0: do_resp(2'd2, $urandom);
          1: do_resp(2'd3, $urandom);
          default: do_resp(2'd0, $urandom);
        endcase
      end
    end

    // TRST in the middle of a DMI scan with a request pending.
    DMI_REQ_READY = 0;
    do_ir(5'h11);
    if (m_stat != 2'd0 || m_busy) begin
      do_ir(5'h10);
      do_dr(64'h1 << 17);
      do_ir(5'h11);
    end
    do_dr({23'd0, 7'h44, 32'h55, 2'd2});
    chk("t6_pending", 64'(DMI_REQ_VALID), 64'h1);
    clk1(1, 0, d); clk1(0, 0, d); clk1(0, 0, d);
    for (int i = 0; i < 10; i++) clk1(0, 1'($urandom), d);
    @(negedge TCK);
    #1 TRST = 1;
    #1;
    chk("trst_valid", 64'(DMI_REQ_VALID), 64'h0);
    chk("trst_tdo", 64'(TDO), 64'h0);
    chk("trst_addr", 64'(DMI_REQ_ADDR), 64'h0);
    #1 TRST = 0;
    m_reset();
    DMI_REQ_READY = 1;
    clk1(0, 0, d);
    do_dr(64'h0);
    do_ir(5'h1F);
    scan_dr(5, 64'h0D, o);
    chk("bypass_after_trst", o, 64'h1A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
